// File: rtl/noc_tb_pkg.sv
// noc_tb_pkg: shared packet-field offsets, counter width and saturating increment
// used by the NoC sink checker and its sequence table.
package noc_tb_pkg;

  localparam int CNT_W = 32;

  // Packet layout from LSB: dest_x, dest_y, source_x, source_y, payload.
  function automatic int dest_x_lsb();
    return 0;
  endfunction

  function automatic int dest_y_lsb(input int dx_w);
    return dx_w;
  endfunction

  function automatic int source_x_lsb(input int dx_w, input int dy_w);
    return dx_w + dy_w;
  endfunction

  function automatic int source_y_lsb(input int dx_w, input int dy_w, input int sx_w);
    return dx_w + dy_w + sx_w;
  endfunction

  function automatic int payload_lsb(input int dx_w, input int dy_w, input int sx_w,
                                     input int sy_w);
    return dx_w + dy_w + sx_w + sy_w;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sink_seq_table.sv
// sink_seq_table: per-source seen flag and last sequence number, with a
// combinational "not strictly increasing" compare for the addressed source.
module sink_seq_table #(
  parameter int NSRC = 16,
  parameter int SEQW = 32,
  parameter int IDXW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_wr,
  input  logic [IDXW-1:0] i_idx,
  input  logic [SEQW-1:0] i_seq,
  output logic            o_order_err
);

  logic [NSRC-1:0] seen_q;
  logic [SEQW-1:0] last_seq_q [NSRC];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen_q <= '0;
    end else if (i_wr) begin
      seen_q[i_idx] <= 1'b1;
    end
  end

  // last_seq needs no clear: an entry is only consulted once its seen bit is set.
  always_ff @(posedge clk) begin
    if (i_wr) begin
      last_seq_q[i_idx] <= i_seq;
    end
  end

  // Storage is read combinationally, so a write at one edge is already visible
  // to the compare in the following cycle (back-to-back packets need no stall).
  assign o_order_err = seen_q[i_idx] && (i_seq <= last_seq_q[i_idx]);

endmodule

// File: rtl/noc_sink_checker.sv
// noc_sink_checker: throttled packet sink that checks delivery address, source
// range and per-source sequence order. `SINK_PER_SRC_COUNT_EN adds per-source counters.
module noc_sink_checker
  import noc_tb_pkg::*;
#(
  parameter int xcord        = 0,
  parameter int ycord        = 0,
  parameter int X            = 4,
  parameter int Y            = 4,
  parameter int dest_x       = 2,
  parameter int dest_y       = 2,
  parameter int source_x     = 8,
  parameter int source_y     = 8,
  parameter int data_width   = 240,
  parameter int total_width  = dest_x + dest_y + source_x + source_y + data_width,
  parameter int SEQW         = 32,
  parameter int stall_period = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [total_width-1:0] i_data,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic                   enable,
  output logic [CNT_W-1:0]       o_pkt_count,
  output logic [CNT_W-1:0]       o_err_count,
  output logic                   o_err_misroute,
  output logic                   o_err_src,
  output logic                   o_err_order,
  output logic [CNT_W-1:0]       o_last_src
`ifdef SINK_PER_SRC_COUNT_EN
  ,
  input  logic [31:0]            i_rd_idx,
  output logic [CNT_W-1:0]       o_src_count
`endif
);

  localparam int NSRC   = X * Y;
  localparam int IDXW   = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int DX_LSB = dest_x_lsb();
  localparam int DY_LSB = dest_y_lsb(dest_x);
  localparam int SX_LSB = source_x_lsb(dest_x, dest_y);
  localparam int SY_LSB = source_y_lsb(dest_x, dest_y, source_x);
  localparam int PL_LSB = payload_lsb(dest_x, dest_y, source_x, source_y);
  localparam int SCW    = (stall_period > 1) ? $clog2(stall_period) : 1;

  logic [dest_x-1:0]   f_dx;
  logic [dest_y-1:0]   f_dy;
  logic [source_x-1:0] f_sx;
  logic [source_y-1:0] f_sy;
  logic [SEQW-1:0]     f_seq;
  logic                pl_unused;

  assign f_dx      = i_data[DX_LSB +: dest_x];
  assign f_dy      = i_data[DY_LSB +: dest_y];
  assign f_sx      = i_data[SX_LSB +: source_x];
  assign f_sy      = i_data[SY_LSB +: source_y];
  assign f_seq     = i_data[PL_LSB +: SEQW];
  assign pl_unused = ^i_data[total_width-1:PL_LSB+SEQW];

  logic             ready_q, ready_d;
  logic [SCW-1:0]   sc_q, sc_d;
  logic             stall_slot;
  logic [CNT_W-1:0] pkt_q, pkt_d, err_q, err_d, last_src_q, last_src_d;
  logic             mis_q, mis_d, srcerr_q, srcerr_d, ord_q, ord_d;
  logic             accept, misroute, src_ok, order_hit, order_err, tbl_wr, any_err;
  logic [CNT_W-1:0] src_pe;
  logic [IDXW-1:0]  src_idx;

  assign accept    = i_valid & ready_q;
  assign misroute  = (32'(f_dx) != 32'(xcord)) || (32'(f_dy) != 32'(ycord));
  assign src_ok    = (32'(f_sx) < 32'(X)) && (32'(f_sy) < 32'(Y));
  assign src_pe    = 32'(f_sy) * 32'(X) + 32'(f_sx);
  assign src_idx   = src_pe[IDXW-1:0];
  // An out-of-range source must neither consult nor disturb the table.
  assign tbl_wr    = accept & src_ok;
  assign order_err = src_ok & order_hit;
  assign any_err   = misroute | ~src_ok | order_err;

  sink_seq_table #(
    .NSRC (NSRC),
    .SEQW (SEQW),
    .IDXW (IDXW)
  ) u_seq_table (
    .clk         (clk),
    .rst         (rst),
    .i_wr        (tbl_wr),
    .i_idx       (src_idx),
    .i_seq       (f_seq),
    .o_order_err (order_hit)
  );

  always_comb begin
    sc_d       = '0;
    stall_slot = 1'b0;
    if (stall_period != 0) begin
      stall_slot = (32'(sc_q) == 32'(stall_period - 1));
      sc_d       = stall_slot ? '0 : sc_q + 1'b1;
    end
    ready_d    = enable & ~stall_slot;
    pkt_d      = pkt_q;
    err_d      = err_q;
    mis_d      = mis_q;
    srcerr_d   = srcerr_q;
    ord_d      = ord_q;
    last_src_d = last_src_q;
    if (accept) begin
      pkt_d      = sat_inc(pkt_q);
      err_d      = any_err ? sat_inc(err_q) : err_q;
      mis_d      = mis_q | misroute;
      srcerr_d   = srcerr_q | ~src_ok;
      ord_d      = ord_q | order_err;
      last_src_d = src_pe;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q    <= 1'b0;
      sc_q       <= '0;
      pkt_q      <= '0;
      err_q      <= '0;
      mis_q      <= 1'b0;
      srcerr_q   <= 1'b0;
      ord_q      <= 1'b0;
      last_src_q <= '0;
    end else begin
      ready_q    <= ready_d;
      sc_q       <= sc_d;
      pkt_q      <= pkt_d;
      err_q      <= err_d;
      mis_q      <= mis_d;
      srcerr_q   <= srcerr_d;
      ord_q      <= ord_d;
      last_src_q <= last_src_d;
    end
  end

  assign o_ready        = ready_q;
  assign o_pkt_count    = pkt_q;
  assign o_err_count    = err_q;
  assign o_err_misroute = mis_q;
  assign o_err_src      = srcerr_q;
  assign o_err_order    = ord_q;
  assign o_last_src     = last_src_q;

`ifdef SINK_PER_SRC_COUNT_EN
  logic [CNT_W-1:0] src_cnt_q [NSRC];
  logic [CNT_W-1:0] rd_cnt_q;

  for (genvar gi = 0; gi < NSRC; gi++) begin : g_src_cnt
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        src_cnt_q[gi] <= '0;
      end else if (tbl_wr && (src_idx == IDXW'(gi))) begin
        src_cnt_q[gi] <= sat_inc(src_cnt_q[gi]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt_q <= '0;
    end else begin
      rd_cnt_q <= (i_rd_idx < 32'(NSRC)) ? src_cnt_q[i_rd_idx[IDXW-1:0]] : '0;
    end
  end

  assign o_src_count = rd_cnt_q;
`endif

endmodule
